// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the architectural PC of the multi-cycle MIPS core. It moves each
//   instruction through fetch, issue and execute, then loads the PC from the
//   next-PC unit. A halt request is honoured once the instruction in flight
//   has retired. A misaligned next PC sends the block into a terminal fault
//   state that only reset can clear.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   pc           : current PC (next-PC unit input and imem address)
//   imem_req     : instruction read request, high in FETCH
//   imem_ack     : imem_rdata valid (used only while imem_req=1)
//   imem_rdata   : instruction word from memory
//   instr        : latched instruction for decode
//   instr_valid  : instr valid, high in ISSUE until accepted
//   instr_ready  : decode accepts instr
//   exec_done    : execute finished, npc_next stable
//   npc_next     : next PC from the next-PC unit
//   halt_req     : stop after the instruction in flight retires
//   resume       : leave HALT and fetch at pc
//   halted       : high in HALT
//   fault        : high in FAULT (sticky until reset)
//   fault_pc     : PC of the instruction whose npc_next was misaligned
//   retired      : count of completed PC updates (wraps)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [31:0]      pc,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             exec_done,
  input  logic [31:0]      npc_next,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      fault_pc_reg, fault_pc_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             halt_pending_reg, halt_pending_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_FETCH;
      pc_reg           <= RESET_PC;
      instr_reg        <= '0;
      fault_pc_reg     <= '0;
      retired_reg      <= '0;
      halt_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      instr_reg        <= instr_next;
      fault_pc_reg     <= fault_pc_next;
      retired_reg      <= retired_next;
      halt_pending_reg <= halt_pending_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    instr_next        = instr_reg;
    fault_pc_next     = fault_pc_reg;
    retired_next      = retired_reg;
    halt_pending_next = halt_pending_reg;

    unique case (state_reg)
      S_FETCH: begin
        if (halt_req) halt_pending_next = 1'b1;
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (halt_req) halt_pending_next = 1'b1;
        if (instr_ready) state_next = S_EXEC;
      end
      S_EXEC: begin
        if (halt_req) halt_pending_next = 1'b1;
        if (exec_done) begin
          if (npc_next[1:0] != 2'b00) begin
            // Misaligned target: the instruction does not retire.
            fault_pc_next = pc_reg;
            state_next    = S_FAULT;
          end else begin
            pc_next      = npc_next;
            retired_next = retired_reg + CNT_W'(1);
            if (halt_pending_reg || halt_req) begin
              halt_pending_next = 1'b0;
              state_next        = S_HALT;
            end else begin
              state_next = S_FETCH;
            end
          end
        end
      end
      S_HALT: begin
        // resume beats halt_req; a simultaneous halt_req arms one more
        // instruction before halting again.
        if (resume) begin
          halt_pending_next = halt_req;
          state_next        = S_FETCH;
        end
      end
      S_FAULT: begin
        // Terminal; everything except reset is ignored.
      end
      default: state_next = S_FAULT;
    endcase
  end

  // imem_req is gated by reset_n so it drops the moment reset asserts,
  // not just at the next clock.
  assign imem_req    = (state_reg == S_FETCH) && reset_n;
  assign instr_valid = (state_reg == S_ISSUE);
  assign halted      = (state_reg == S_HALT);
  assign fault       = (state_reg == S_FAULT);
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign fault_pc    = fault_pc_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Drives the fetch sequencer as instruction memory, decode and execute
//   would. Expected per-instruction results are queued when the fetch is
//   acknowledged and compared once the PC update is visible.
module tb_fetch_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      pc;
  logic             imem_req;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             exec_done;
  logic [31:0]      npc_next;
  logic             halt_req;
  logic             resume;
  logic             halted;
  logic             fault;
  logic [31:0]      fault_pc;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .exec_done(exec_done), .npc_next(npc_next), .halt_req(halt_req),
    .resume(resume), .halted(halted), .fault(fault), .fault_pc(fault_pc),
    .retired(retired)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_after;
    logic [3:0]  ret_after;
    logic        flt;
    logic        hlt;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          ack_wait;
    int          rdy_wait;
    int          exec_wait;
    logic [31:0] npc;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [3:0]  model_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Runs one instruction end to end. Called and returns just after a
  // falling edge. Ignored-input pulses are driven during every wait.
  task automatic do_instr(input logic [31:0] rdata, input int ack_wait,
                          input int rdy_wait, input int exec_wait,
                          input logic [31:0] npc, input logic hreq,
                          input logic exp_halt);
    int          n;
    exp_t        e;
    logic [31:0] pc0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk1("fetch_timeout", imem_req, 1'b1);
      return;
    end
    chk("fetch_addr", pc, model_pc);
    pc0      = model_pc;
    halt_req = hreq;
    for (int i = 0; i < ack_wait; i++) begin
      exec_done   = 1'b1;
      instr_ready = 1'b1;
      npc_next    = 32'hdead_beec;
      @(negedge clk);
      halt_req    = 1'b0;
      exec_done   = 1'b0;
      instr_ready = 1'b0;
      chk1("req_held", imem_req, 1'b1);
      chk("pc_hold_fetch", pc, pc0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    e.instr = rdata;
    if (npc[1:0] != 2'b00) begin
      e.pc_after  = pc0;
      e.ret_after = model_ret;
      e.flt       = 1'b1;
      e.hlt       = 1'b0;
    end else begin
      e.pc_after  = npc;
      e.ret_after = model_ret + 4'd1;
      e.flt       = 1'b0;
      e.hlt       = exp_halt;
    end
    exp_q.push_back(e);
    @(negedge clk);
    halt_req = 1'b0;
    imem_ack = 1'b0;
    chk1("issue_valid", instr_valid, 1'b1);
    chk1("issue_req_low", imem_req, 1'b0);
    chk("issue_instr", instr, exp_q[0].instr);
    for (int i = 0; i < rdy_wait; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~rdata;
      exec_done  = 1'b1;
      @(negedge clk);
      imem_ack  = 1'b0;
      exec_done = 1'b0;
      chk1("valid_held", instr_valid, 1'b1);
      chk("instr_stable", instr, exp_q[0].instr);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk1("exec_valid_low", instr_valid, 1'b0);
    for (int i = 0; i < exec_wait; i++) begin
      instr_ready = 1'b1;
      imem_ack    = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      imem_ack    = 1'b0;
      chk("pc_hold_exec", pc, pc0);
      chk1("exec_req_low", imem_req, 1'b0);
    end
    exec_done = 1'b1;
    npc_next  = npc;
    @(negedge clk);
    exec_done = 1'b0;
    if (exp_q.size() == 0) begin
      chk1("scoreboard_empty", 1'b0, 1'b1);
      return;
    end
    e = exp_q.pop_front();
    chk("pc_after", pc, e.pc_after);
    chk("retired", 32'(retired), 32'(e.ret_after));
    chk1("fault", fault, e.flt);
    chk1("halted", halted, e.hlt);
    chk1("req_after", imem_req, !e.flt && !e.hlt);
    if (e.flt) chk("fault_pc", fault_pc, pc0);
    model_pc  = e.pc_after;
    model_ret = e.ret_after;
    $display("txn pc=%h instr=%h npc=%h retired=%0d fault=%b halted=%b",
             pc0, rdata, npc, retired, fault, halted);
  endtask

  task automatic apply_reset_release();
    @(negedge clk);
    reset_n   = 1'b1;
    model_pc  = 32'h0000_3000;
    model_ret = 4'd0;
    #1;
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{32'h3c01_0001, 0, 0, 0, 32'h0000_3004};
    tbl[1] = '{32'h8c22_0000, 4, 3, 1, 32'h0000_3008};
    tbl[2] = '{32'h1000_00ff, 0, 1, 2, 32'h0000_3400};
    tbl[3] = '{32'h0000_0020, 1, 0, 0, 32'h0000_3404};

    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    exec_done = 1'b0; npc_next = '0; halt_req = 1'b0; resume = 1'b0;
    model_pc = 32'h0000_3000; model_ret = 4'd0;

    repeat (2) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    apply_reset_release();
    chk1("release_req", imem_req, 1'b1);

    // Table: basic flow, backpressure, jump.
    for (int i = 0; i < 4; i++)
      do_instr(tbl[i].rdata, tbl[i].ack_wait, tbl[i].rdy_wait,
               tbl[i].exec_wait, tbl[i].npc, 1'b0, 1'b0);

    // Halt requested during FETCH: the instruction completes first.
    do_instr(32'h2401_0005, 1, 0, 0, 32'h0000_3500, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exec_done = 1'b1; npc_next = 32'h0000_4000; imem_ack = 1'b1;
      @(negedge clk);
      exec_done = 1'b0; imem_ack = 1'b0;
      chk1("halt_hold", halted, 1'b1);
      chk("halt_pc_frozen", pc, 32'h0000_3500);
    end
    // resume with halt_req: exactly one more instruction, then halt again.
    resume = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    resume = 1'b0; halt_req = 1'b0;
    chk1("resume_leaves_halt", halted, 1'b0);
    do_instr(32'h2401_0006, 0, 0, 0, 32'h0000_3504, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk1("rehalt_hold", halted, 1'b1);
    chk("rehalt_retired", 32'(retired), 32'(model_ret));
    chk1("rehalt_no_req", imem_req, 1'b0);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;

    // Reset mid-ISSUE, off the clock edge.
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    @(negedge clk);
    imem_ack = 1'b0;
    chk1("pre_rst_issue", instr_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("rst_issue_valid", instr_valid, 1'b0);
    chk1("rst_issue_req", imem_req, 1'b0);
    chk("rst_issue_pc", pc, 32'h0000_3000);
    chk("rst_issue_ret", 32'(retired), 32'd0);
    apply_reset_release();
    do_instr(32'h3c01_0001, 0, 0, 0, 32'h0000_3004, 1'b0, 1'b0);

    // Reset mid-EXEC, off the clock edge.
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk1("rst_exec_req", imem_req, 1'b0);
    chk("rst_exec_pc", pc, 32'h0000_3000);
    chk("rst_exec_ret", 32'(retired), 32'd0);
    apply_reset_release();

    // Counter wrap: 15 retires, then the 16th returns to zero.
    for (int i = 0; i < 15; i++)
      do_instr(32'h0000_0000 + 32'(i), 0, 0, 0, model_pc + 32'd4, 1'b0, 1'b0);
    chk("retired_max", 32'(retired), 32'd15);
    do_instr(32'h0000_00aa, 0, 0, 0, model_pc + 32'd4, 1'b0, 1'b0);
    chk("retired_wrap", 32'(retired), 32'd0);

    // Jump, then misaligned target traps.
    do_instr(32'h0800_0d00, 0, 0, 0, 32'h0000_3400, 1'b0, 1'b0);
    do_instr(32'h0800_0d00, 0, 0, 0, 32'h0000_3402, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exec_done = 1'b1; resume = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
      halt_req = 1'b1; npc_next = 32'h0000_5000;
      @(negedge clk);
      exec_done = 1'b0; resume = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
      halt_req = 1'b0;
      chk1("fault_sticky", fault, 1'b1);
      chk1("fault_no_req", imem_req, 1'b0);
      chk("fault_pc_hold", pc, 32'h0000_3400);
      chk("fault_pc_val", fault_pc, 32'h0000_3400);
    end
    reset_n = 1'b0;
    #1;
    chk1("fault_cleared", fault, 1'b0);
    chk("fault_pc_cleared", fault_pc, 32'd0);
    apply_reset_release();
    chk1("post_fault_req", imem_req, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
